// File: rtl/mem_port_pkg.sv
// Shared state encoding and geometry constants for the bit-serial memory word port.
package mem_port_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 7;
  localparam int BIT_W  = 4;

  localparam logic [BIT_W-1:0] LAST_BIT = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WSET,
    WSTB,
    WHLD,
    DONE
  } state_t;

endpackage

// File: rtl/mem_bit_counter.sv
// Bit index for the serial memory: clears on accept, saturates at LAST_BIT so it
// can never leave the 0..11 range.
module mem_bit_counter
  import mem_port_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [BIT_W-1:0] o_idx,
  output logic             o_last
);

  logic [BIT_W-1:0] r_idx;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc && !o_last) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_idx == LAST_BIT);

endmodule

// File: rtl/mem_word_port.sv
// Word-wide access port onto a bit-serial memory: 12 read cycles or 12 x 3-cycle
// write strobes, LSB first. Define MEM_WORD_PORT_VERIFY_EN to enable write-verify (err).
module mem_word_port
  import mem_port_pkg::*;
(
  input  logic              sysclk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mabus,
  output logic [BIT_W-1:0]  babus,
  output logic              mbbus,
  output logic              write,
  input  logic              membus,
  output logic              err
);

  state_t            r_state;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mabus;
  logic              r_busy;
  logic              r_done;
  logic              r_mbbus;
  logic              r_write;

  logic              w_accept;
  logic              w_inc;
  logic              w_last;
  logic [BIT_W-1:0]  w_idx;
  logic [BIT_W-1:0]  w_idx_nxt;

  assign w_accept  = (r_state == IDLE) && req;
  assign w_inc     = (r_state == RD) || (r_state == WHLD);
  assign w_idx_nxt = w_idx + 4'd1;

  mem_bit_counter u_bit_counter (
    .clk    (sysclk),
    .rst_n  (reset),
    .i_clr  (w_accept),
    .i_inc  (w_inc),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  // The write strobe is registered and only ever set on the WSET->WSTB edge, so a
  // read can never produce a strobe and a reset in WSTB drops it asynchronously.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mabus <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mbbus <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_mabus <= addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            if (we) begin
              r_mbbus <= wdata[0];
              r_state <= WSET;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD: begin
          r_rdata[w_idx] <= membus;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        WSET: begin
          r_write <= 1'b1;
          r_state <= WSTB;
        end
        WSTB: begin
          r_write <= 1'b0;
          r_state <= WHLD;
        end
        WHLD: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_mbbus <= r_wdata[w_idx_nxt];
            r_state <= WSET;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_WORD_PORT_VERIFY_EN
  logic r_err;

  // Memory read-back is compared on the WHLD edge, after the strobe has committed the bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((r_state == WHLD) && (membus != r_mbbus)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign rdata = r_rdata;
  assign busy  = r_busy;
  assign done  = r_done;
  assign mabus = r_mabus;
  assign babus = w_idx;
  assign mbbus = r_mbbus;
  assign write = r_write;

endmodule

// File: tb/tb_mem_word_port.sv
// Self-checking bench for mem_word_port: bit-serial memory model, transaction-level
// reference model with a per-cycle compare, directed scenarios and random traffic.
module tb_mem_word_port;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic        req    = 1'b0;
  logic        we     = 1'b0;
  logic [6:0]  addr   = '0;
  logic [11:0] wdata  = '0;
  logic [11:0] rdata;
  logic        busy;
  logic        done;
  logic [6:0]  mabus;
  logic [3:0]  babus;
  logic        mbbus;
  logic        write;
  logic        membus;
  logic        err;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int wr_edges = 0;

  always #5 sysclk = ~sysclk;

  mem_word_port dut (
    .sysclk (sysclk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .mabus  (mabus),
    .babus  (babus),
    .mbbus  (mbbus),
    .write  (write),
    .membus (membus),
    .err    (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bit-serial memory (commits on falling edge of write) ----------------
  logic [11:0] mem     [128];
  logic [11:0] ref_mem [128];
  logic        stuck3 = 1'b0;
  logic [6:0]  cap_a;
  logic [3:0]  cap_b;
  logic        cap_d;

  assign membus = (stuck3 && babus == 4'd3) ? 1'b0 : mem[mabus][babus];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[7'o110] = 12'o0007;
    forever begin
      @(posedge write);
      cap_a = mabus;
      cap_b = babus;
      cap_d = mbbus;
      @(negedge write);
      mem[cap_a][cap_b] = (stuck3 && cap_b == 4'd3) ? 1'b0 : cap_d;
      wr_edges++;
    end
  end

  // ---------------- reference model: cycles since accept ----------------
  int          mt     = 0;
  logic        mwe    = 1'b0;
  logic [6:0]  m_addr = '0;
  logic [11:0] mwdata = '0;
  logic [11:0] m_rdata = '0;
  logic [3:0]  m_hbab = '0;
  logic        m_mbb  = 1'b0;
  logic        m_err  = 1'b0;

  function automatic int op_len(input logic w);
    return w ? 37 : 13;
  endfunction

  task automatic commit(input int k);
    ref_mem[m_addr][k] = (stuck3 && k == 3) ? 1'b0 : mwdata[k];
  endtask

  initial begin
    int k;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    ref_mem[7'o110] = 12'o0007;
    forever begin
      @(posedge sysclk or negedge reset);
      if (!reset) begin
        if (mt != 0 && mwe && mt <= 36 && (mt - 1) % 3 == 1) commit((mt - 1) / 3);
        mt = 0; m_addr = '0; m_rdata = '0; m_hbab = '0; m_mbb = 1'b0; m_err = 1'b0;
      end else if (mt == 0) begin
        if (req) begin
          mt = 1; mwe = we; m_addr = addr; mwdata = wdata; m_err = 1'b0; m_hbab = '0;
          if (we) m_mbb = wdata[0];
        end
      end else if (mt == op_len(mwe)) begin
        mt = 0;
      end else begin
        if (mwe && (mt - 1) % 3 == 2) begin
          k = (mt - 1) / 3;
`ifdef MEM_WORD_PORT_VERIFY_EN
          if (ref_mem[m_addr][k] !== mwdata[k]) m_err = 1'b1;
`endif
        end
        mt++;
        if (mwe && mt <= 36 && (mt - 1) % 3 == 2) commit((mt - 1) / 3);
        if (mt == op_len(mwe)) begin
          m_hbab = 4'd11;
          if (mwe) m_mbb = mwdata[11];
          else     m_rdata = ref_mem[m_addr];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    int lastt;
    int k;
    logic e_write;
    logic [3:0] e_bab;
    logic e_mbb;
    forever begin
      @(negedge sysclk);
      lastt   = op_len(mwe);
      k       = (mt > 0) ? (mt - 1) / 3 : 0;
      e_write = (mt != 0) && mwe && (mt <= 36) && ((mt - 1) % 3 == 1);
      if (mt == 0)          e_bab = m_hbab;
      else if (mt == lastt) e_bab = 4'd11;
      else if (mwe)         e_bab = 4'(k);
      else                  e_bab = 4'(mt - 1);
      if (mt != 0 && mwe) e_mbb = (mt == lastt) ? mwdata[11] : mwdata[k];
      else                e_mbb = m_mbb;
      check("busy",  busy,  (mt != 0));
      check("done",  done,  (mt != 0 && mt == lastt));
      check("write", write, e_write);
      check("babus", babus, e_bab);
      check("mabus", mabus, m_addr);
      check("mbbus", mbbus, e_mbb);
      check("err",   err,   m_err);
      if (!(mt != 0 && !mwe && mt < 13)) check("rdata", rdata, m_rdata);
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic access(input logic w, input logic [6:0] a, input logic [11:0] d, output int lat);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0;
    wait_done(lat);
    tick();
  endtask

  initial begin
    int lat;
    int e0;
    int d0;

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_write", write, 0);
    check("rst_babus", babus, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b1;
    tick();

    // preloaded read
    e0 = wr_edges;
    access(1'b0, 7'o110, 12'o0000, lat);
    check("rd_latency", lat, 13);
    check("rd_word", rdata, 12'o0007);
    check("rd_no_write", wr_edges - e0, 0);

    // write then read back
    e0 = wr_edges;
    access(1'b1, 7'o107, 12'o7770, lat);
    check("wr_latency", lat, 37);
    check("wr_edges", wr_edges - e0, 12);
    check("wr_mem", mem[7'o107], 12'o7770);
    access(1'b0, 7'o107, 12'o0000, lat);
    check("wr_readback", rdata, 12'o7770);

    // request during busy read is dropped
    d0 = done_cnt;
    req = 1'b1; we = 1'b0; addr = 7'o106;
    tick();
    req = 1'b0;
    repeat (3) tick();
    req = 1'b1; addr = 7'o100;
    tick();
    req = 1'b0;
    repeat (20) tick();
    check("ign_done_cnt", done_cnt - d0, 1);
    check("ign_mabus", mabus, 7'o106);

    // back-to-back with req held high
    d0 = done_cnt;
    req = 1'b1; we = 1'b0; addr = 7'o110;
    tick();
    wait_done(lat);
    check("b2b_lat1", lat, 13);
    tick();
    check("b2b_gap", busy, 0);
    tick();
    check("b2b_second", busy, 1);
    req = 1'b0;
    wait_done(lat);
    check("b2b_lat2", lat, 13);
    repeat (5) tick();
    check("b2b_done_cnt", done_cnt - d0, 2);

    // reset during WSTB of bit 5
    req = 1'b1; we = 1'b1; addr = 7'o050; wdata = 12'o7777;
    tick();
    req = 1'b0;
    repeat (16) tick();
    check("wstb_write", write, 1);
    reset = 1'b0;
    #1;
    check("rst_now_write", write, 0);
    check("rst_now_busy", busy, 0);
    check("rst_now_mabus", mabus, 0);
    check("rst_now_babus", babus, 0);
    check("rst_now_mbbus", mbbus, 0);
    check("rst_now_rdata", rdata, 0);
    tick();
    reset = 1'b1;
    tick();
    check("rst_mem", mem[7'o050], 12'o0077);

`ifdef MEM_WORD_PORT_VERIFY_EN
    stuck3 = 1'b1;
    access(1'b1, 7'o030, 12'o0010, lat);
    check("vfy_err_set", err, 1);
    req = 1'b1; we = 1'b0; addr = 7'o030;
    tick();
    req = 1'b0;
    check("vfy_err_clr", err, 0);
    wait_done(lat);
    tick();
    stuck3 = 1'b0;
`endif

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(399) == 0) begin
        req = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        req   = ($urandom_range(2) == 0);
        we    = $urandom_range(1) == 1;
        addr  = 7'($urandom);
        wdata = 12'($urandom);
      end
      tick();
    end
    req = 1'b0;
    repeat (50) tick();
    for (int i = 0; i < 128; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_word_port.md
MEM_WORD_PORT -- requirements
Module: mem_word_port

Interface
REQ-001 SHALL have port sysclk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req, input, 1 bit: word access request, sampled only in IDLE.
REQ-004 SHALL have port we, input, 1 bit: 1 = write word, 0 = read word; latched with req.
REQ-005 SHALL have port addr, input, 7 bits: word address; latched with req.
REQ-006 SHALL have port wdata, input, 12 bits: write word; latched with req.
REQ-007 SHALL have port rdata, output, 12 bits: assembled read word; valid while done=1 and held until the next accepted read.
REQ-008 SHALL have port busy, output, 1 bit: high from the accept edge until DONE is left.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port mabus, output, 7 bits: word address to the bit-serial memory.
REQ-011 SHALL have port babus, output, 4 bits: bit index to the memory, range 0..11.
REQ-012 SHALL have port mbbus, output, 1 bit: serial write data bit.
REQ-013 SHALL have port write, output, 1 bit: write strobe; the memory commits mbbus on its falling edge.
REQ-014 SHALL have port membus, input, 1 bit: serial read bit from the memory, combinationally valid for the current mabus/babus.
REQ-015 SHALL have port err, output, 1 bit: write-verify mismatch flag (see Configuration).

Function
REQ-016 SHALL use states IDLE, RD, WSET, WSTB, WHLD and DONE.
REQ-017 In IDLE with req=1, SHALL latch addr, we and wdata, drive mabus=addr and babus=0, and go to RD (we=0) or WSET (we=1).
REQ-018 In RD, each edge SHALL do rdata[babus] <= membus; at babus=11 it SHALL go to DONE, otherwise babus SHALL increment; total 12 RD cycles.
REQ-019 In WSET, SHALL drive mbbus=wdata[babus] with write=0, then go to WSTB.
REQ-020 In WSTB, SHALL drive write=1 for exactly one cycle, then go to WHLD.
REQ-021 In WHLD, SHALL drive write=0 and hold mabus, babus and mbbus stable for the full cycle; at babus=11 it SHALL go to DONE, otherwise babus SHALL increment and the state SHALL return to WSET.
REQ-022 A word write SHALL take 36 cycles and produce exactly 12 falling edges on write, with bit order LSB first (babus 0..11).
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE; the next req SHALL be accepted no earlier than the IDLE cycle that follows.
REQ-024 req asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 mabus SHALL change only at an accept edge; babus SHALL never exceed 11.
REQ-026 write SHALL be 1 only in WSTB, so no write strobe can occur during a read.

Reset
REQ-027 While reset=0, SHALL force state=IDLE, busy=0, done=0, err=0, write=0, mbbus=0, mabus=0, babus=0 and rdata=0.
REQ-028 Reset asserted in WSTB produces a falling edge on write; the bit currently driven SHALL be committed, and bits already committed SHALL remain in memory (documented behaviour, not an error).

Configuration
REQ-029 With MEM_WORD_PORT_VERIFY_EN defined, SHALL compare membus with mbbus on the WHLD edge of each bit and set err on a mismatch; err SHALL stay set until the next accepted req clears it.
REQ-030 Without MEM_WORD_PORT_VERIFY_EN, err SHALL be tied to 0, and write timing SHALL be identical to the verify build.

Structure
REQ-031 Package mem_port_pkg SHALL hold the state enumeration and the constants WORD_W=12, ADDR_W=7 and LAST_BIT=11.
REQ-032 The bit index SHALL be implemented in one sub-module, mem_bit_counter, providing clear, increment and last-bit flag.

Verification
REQ-033 Preload m[0110]=0007, read addr=0110 -> rdata=0007, done high 13 cycles after the accept edge, and no write edges.
REQ-034 Write addr=0107, wdata=7770 -> 12 write negedges, then m[0107]=7770; a following read returns 7770.
REQ-035 Pulse req with addr=0100 during a busy read of 0106 -> the second request is ignored and only one done pulse occurs.
REQ-036 Apply reset during WSTB of bit 5 of a write of 7777 over 0000 -> outputs take reset values at once, and the memory word is 0077.
REQ-037 VERIFY_EN build, memory model with bit 3 stuck at 0, write 0010 -> err=1 after DONE; the next req clears err to 0.
REQ-038 Issue back-to-back requests with req held high -> the second access is accepted in the IDLE cycle after DONE, and busy has a one-cycle low gap between the two accesses.
